// File: rtl/mmio_pkg.sv
// Shared types and defaults for the two-master MMIO arbiter.
package mmio_pkg;

    // Arbiter FSM: wait for a request, wait on the fabric, pulse completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd255;
    localparam logic [31:0] DEF_ERR_RDATA      = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. The requester not served last wins a tie;
// a lone requester always wins. Purely combinational.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,   // 0 = m0 served last, 1 = m1 served last
    output logic [1:0] grant         // one-hot, all zero when nobody requests
);

    // Tie goes to whoever was not granted last; otherwise pass the request through.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mmio_arb.sv
// Two-master to one-slave MMIO arbiter with a per-transaction wait timeout.
// One transaction is in flight at a time: grant -> BUSY (slave request held
// stable) -> RESP (one-cycle ready pulse to the owning master).
module mmio_arb
    import mmio_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_we,
    input  logic        m0_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_we,
    input  logic        m1_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_we,
    output logic        s_valid,
    input  logic [31:0] s_rdata,
    input  logic        s_ready
);

    // The timeout fires in the BUSY cycle that would bring the wait count to
    // TIMEOUT_CYCLES, so s_valid is held for exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] LAST_WAIT = TIMEOUT_CYCLES - 16'd1;

    state_t      state_reg, state_next;
    logic        owner_reg, owner_next;      // master in service, doubles as last grant
    logic [15:0] wait_reg, wait_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  wstrb_reg, wstrb_next;
    logic        we_reg, we_next;
    logic        valid_reg, valid_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;

    logic [1:0]  req;
    logic [1:0]  grant;
    logic [1:0]  done;

    assign req = {m1_valid, m0_valid};

    rr_arb2 u_rr (
        .req        (req),
        .last_grant (owner_reg),
        .grant      (grant)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Slave request, response and bookkeeping registers; owner resets to m1 so m0 wins first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_reg <= 1'b1;
            wait_reg  <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            we_reg    <= 1'b0;
            valid_reg <= 1'b0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            owner_reg <= owner_next;
            wait_reg  <= wait_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
            we_reg    <= we_next;
            valid_reg <= valid_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic: arbitrate only in IDLE, freeze the request in BUSY.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        wait_next  = wait_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wstrb_next = wstrb_reg;
        we_next    = we_reg;
        valid_next = valid_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    owner_next = grant[1];
                    addr_next  = grant[0] ? m0_addr  : m1_addr;
                    wdata_next = grant[0] ? m0_wdata : m1_wdata;
                    wstrb_next = grant[0] ? m0_wstrb : m1_wstrb;
                    we_next    = grant[0] ? m0_we    : m1_we;
                    valid_next = 1'b1;
                    wait_next  = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    // A slave answer in the timeout cycle still counts as success.
                    rdata_next = s_rdata;
                    err_next   = 1'b0;
                    valid_next = 1'b0;
                    state_next = RESP;
                end else begin
                    wait_next = wait_reg + 16'd1;
                    if (wait_reg == LAST_WAIT) begin
                        rdata_next = ERR_RDATA;
                        err_next   = 1'b1;
                        valid_next = 1'b0;
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Completion pulse goes only to the owner; everything else stays zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_done
        assign done[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end

    assign m0_ready = done[0];
    assign m0_rdata = done[0] ? rdata_reg : '0;
    assign m0_err   = done[0] & err_reg;
    assign m1_ready = done[1];
    assign m1_rdata = done[1] ? rdata_reg : '0;
    assign m1_err   = done[1] & err_reg;

    assign s_addr  = addr_reg;
    assign s_wdata = wdata_reg;
    assign s_wstrb = wstrb_reg;
    assign s_we    = we_reg;
    assign s_valid = valid_reg;

endmodule

// File: tb/tb_mmio_arb.sv
// Randomized scoreboard bench for mmio_arb: rounds of requests from one or
// both masters, a latency-programmable slave, and a monitor that checks the
// slave-side request and the master-side completion against queued expectations.
module tb_mmio_arb;

    localparam int          TOI  = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_we = 1'b0, m0_valid = 1'b0, m1_we = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic [3:0]  s_wstrb;
    logic        s_we, s_valid;
    logic [31:0] s_rdata;
    logic        s_ready;

    int total = 0;
    int bad   = 0;

    // k = BUSY cycle in which the slave answers; k > TOI means it never does.
    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
        int          k;
        logic [31:0] sdata;
    } txn_t;

    txn_t req_q[$];
    txn_t rsp_q[$];
    txn_t slv_q[$];
    int   model_last = 1;

    mmio_arb #(.TIMEOUT_CYCLES(16'(TOI)), .ERR_RDATA(ERRD)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_we(m0_we),
        .m0_valid(m0_valid), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_we(m1_we),
        .m1_valid(m1_valid), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_we(s_we),
        .s_valid(s_valid), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        total++;
        bad++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    function automatic logic [31:0] exp_rdata(input txn_t t);
        return (t.k <= TOI) ? t.sdata : ERRD;
    endfunction

    function automatic logic [31:0] exp_err(input txn_t t);
        return (t.k <= TOI) ? 32'd0 : 32'd1;
    endfunction

    function automatic int exp_len(input txn_t t);
        return (t.k <= TOI) ? t.k : TOI;
    endfunction

    function automatic txn_t make_txn(input int m);
        txn_t t;
        t.m     = m;
        t.addr  = $urandom;
        t.wdata = $urandom;
        t.wstrb = 4'($urandom);
        t.we    = 1'($urandom);
        t.k     = $urandom_range(1, TOI + 2);
        t.sdata = $urandom;
        return t;
    endfunction

    function automatic logic rdy(input int m);
        return (m == 0) ? m0_ready : m1_ready;
    endfunction

    task automatic load(input txn_t t);
        if (t.m == 0) begin
            m0_addr = t.addr; m0_wdata = t.wdata; m0_wstrb = t.wstrb; m0_we = t.we; m0_valid = 1'b1;
        end else begin
            m1_addr = t.addr; m1_wdata = t.wdata; m1_wstrb = t.wstrb; m1_we = t.we; m1_valid = 1'b1;
        end
    endtask

    // Granted master wiggles its inputs (and maybe drops valid) while in service.
    task automatic scramble(input int m, input bit drop);
        if (m == 0) begin
            m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom); m0_we = 1'($urandom);
            if (drop) m0_valid = 1'b0;
        end else begin
            m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom); m1_we = 1'($urandom);
            if (drop) m1_valid = 1'b0;
        end
    endtask

    task automatic set_valid(input int m, input logic v);
        if (m == 0) m0_valid = v;
        else        m1_valid = v;
    endtask

    // One round: raise the chosen requests together, predict service order, run to completion.
    task automatic run_round(input logic [1:0] mask, input txn_t t0, input txn_t t1, input bit drop);
        int   order[2];
        int   n;
        int   pos;
        int   guard;
        txn_t t;
        t0.m = 0;
        t1.m = 1;
        if (mask == 2'b11) begin
            order[0] = (model_last == 1) ? 0 : 1;
            order[1] = 1 - order[0];
            n = 2;
        end else begin
            order[0] = mask[1] ? 1 : 0;
            order[1] = 0;
            n = 1;
        end
        model_last = order[n-1];
        for (int i = 0; i < n; i++) begin
            t = (order[i] == 0) ? t0 : t1;
            req_q.push_back(t);
            rsp_q.push_back(t);
            slv_q.push_back(t);
        end
        if (mask[0]) load(t0);
        if (mask[1]) load(t1);
        pos   = 0;
        guard = 0;
        while (pos < n && guard < 200) begin
            @(negedge clk);
            guard++;
            if (rdy(order[pos])) begin
                set_valid(order[pos], 1'b0);
                pos++;
            end else if (s_valid) begin
                scramble(order[pos], drop);
            end
        end
        if (pos < n) fail_note("round_timeout");
    endtask

    // Slave model: answers in BUSY cycle k of each request, garbage data otherwise.
    initial begin
        int   cnt;
        txn_t cur;
        cnt     = 0;
        cur.k   = 1000;
        s_ready = 1'b0;
        s_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst || !s_valid) begin
                cnt     = 0;
                s_ready = 1'b0;
                s_rdata = $urandom;
            end else begin
                if (cnt == 0) begin
                    if (slv_q.size() > 0) cur = slv_q.pop_front();
                    else                  cur.k = 1000;
                end
                cnt++;
                if (cnt == cur.k) begin
                    s_ready = 1'b1;
                    s_rdata = cur.sdata;
                end else begin
                    s_ready = 1'b0;
                    s_rdata = $urandom;
                end
            end
        end
    end

    // Monitor: checks slave request on s_valid, completion on mN_ready.
    initial begin
        logic pv;
        logic prev_rdy;
        int   len;
        txn_t cur;
        txn_t r;
        pv       = 1'b0;
        prev_rdy = 1'b0;
        len      = 0;
        cur      = make_txn(0);
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv       = 1'b0;
                prev_rdy = 1'b0;
                len      = 0;
            end else begin
                if (s_valid && !pv) begin
                    if (req_q.size() == 0) begin
                        fail_note("unexpected_s_valid");
                    end else begin
                        cur = req_q.pop_front();
                        chk("s_addr", s_addr, cur.addr);
                        chk("s_wdata", s_wdata, cur.wdata);
                        chk("s_wstrb", 32'(s_wstrb), 32'(cur.wstrb));
                        chk("s_we", 32'(s_we), 32'(cur.we));
                    end
                    len = 1;
                end else if (s_valid && pv) begin
                    chk("s_addr_stable", s_addr, cur.addr);
                    chk("s_wdata_stable", s_wdata, cur.wdata);
                    chk("s_wstrb_stable", 32'(s_wstrb), 32'(cur.wstrb));
                    len++;
                end else if (!s_valid && pv) begin
                    chk("busy_len", 32'(len), 32'(exp_len(cur)));
                end
                if (m0_ready || m1_ready) begin
                    chk("ready_one_cycle", 32'(prev_rdy), 32'd0);
                    chk("s_valid_low_in_resp", 32'(s_valid), 32'd0);
                    if (rsp_q.size() == 0) begin
                        fail_note("unexpected_ready");
                    end else begin
                        r = rsp_q.pop_front();
                        chk("ready_owner", {30'd0, m1_ready, m0_ready}, (r.m == 0) ? 32'd1 : 32'd2);
                        chk("rdata", (r.m == 0) ? m0_rdata : m1_rdata, exp_rdata(r));
                        chk("err", 32'((r.m == 0) ? m0_err : m1_err), exp_err(r));
                        chk("other_rdata", (r.m == 0) ? m1_rdata : m0_rdata, 32'd0);
                        chk("other_err", 32'((r.m == 0) ? m1_err : m0_err), 32'd0);
                        $display("txn m%0d addr=%h we=%0d k=%0d rdata=%h err=%0d",
                                 r.m, r.addr, r.we, r.k,
                                 (r.m == 0) ? m0_rdata : m1_rdata,
                                 (r.m == 0) ? m0_err : m1_err);
                    end
                end
                pv       = s_valid;
                prev_rdy = m0_ready | m1_ready;
            end
        end
    end

    // Main sequence: reset, directed cases, random rounds, mid-BUSY reset.
    initial begin
        txn_t a;
        txn_t b;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_s_wdata", s_wdata, 32'd0);
        chk("rst_ctrl", {23'd0, s_wstrb, s_we, s_valid, m0_ready, m0_err, m1_ready, m1_err}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Contention out of reset: m0 first, then m1; repeat to see alternation.
        run_round(2'b11, make_txn(0), make_txn(1), 1'b0);
        run_round(2'b11, make_txn(0), make_txn(1), 1'b0);

        // m0 read of a known address, slave answers two cycles after s_valid.
        a = make_txn(0);
        a.addr = 32'h4000_4010; a.we = 1'b0; a.k = 3; a.sdata = 32'h1234_5678;
        run_round(2'b01, a, make_txn(1), 1'b0);

        // Slave never answers: error completion after TOI wait cycles.
        a = make_txn(0);
        a.k = TOI + 2;
        run_round(2'b01, a, make_txn(1), 1'b0);

        // Slave answers in the timeout cycle: success wins.
        a = make_txn(0);
        a.k = TOI;
        run_round(2'b01, a, make_txn(1), 1'b0);

        // m1 write with partial strobes while its inputs toggle during BUSY.
        b = make_txn(1);
        b.we = 1'b1; b.wstrb = 4'b0011; b.k = 3;
        run_round(2'b10, make_txn(0), b, 1'b0);

        // Granted master drops valid mid-transaction; completion still expected.
        run_round(2'b01, make_txn(0), make_txn(1), 1'b1);

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_round(2'($urandom_range(1, 3)), make_txn(0), make_txn(1), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of BUSY abandons the transaction.
        a = make_txn(0);
        a.k = TOI + 10;
        req_q.push_back(a);
        rsp_q.push_back(a);
        slv_q.push_back(a);
        load(a);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_s_valid", 32'(s_valid), 32'd0);
        chk("midrst_s_addr", s_addr, 32'd0);
        chk("midrst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        req_q.delete();
        rsp_q.delete();
        slv_q.delete();
        m0_valid   = 1'b0;
        model_last = 1;
        repeat (2) begin
            @(negedge clk);
            chk("no_ready_in_reset", {30'd0, m1_ready, m0_ready}, 32'd0);
        end
        #2 rst = 1'b1;
        run_round(2'b11, make_txn(0), make_txn(1), 1'b0);

        repeat (3) @(negedge clk);
        chk("leftover_rsp", 32'(rsp_q.size()), 32'd0);
        chk("leftover_req", 32'(req_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_arb.md
MMIO_ARB -- requirements
Module: mmio_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd255, slave wait cycles before error completion (1..65535).
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF, rdata returned on timeout.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 m0_addr / m1_addr  input  32  master byte address.
REQ-006 m0_wdata / m1_wdata  input  32  master write data.
REQ-007 m0_wstrb / m1_wstrb  input  4  master byte enables.
REQ-008 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-009 m0_valid / m1_valid  input  1  request; held until the matching ready.
REQ-010 m0_rdata / m1_rdata  output  32  read data, valid with ready.
REQ-011 m0_ready / m1_ready  output  1  one-cycle completion pulse.
REQ-012 m0_err / m1_err  output  1  timeout flag, valid with ready.
REQ-013 s_addr, s_wdata, s_wstrb, s_we  output  32/32/4/1  registered request toward the MMIO fabric.
REQ-014 s_valid  output  1  registered slave request.
REQ-015 s_rdata  input  32  slave read data.
REQ-016 s_ready  input  1  slave completion; fabric may repeat it every cycle while s_valid is held.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-018 In IDLE with any mN_valid set, the block SHALL grant one master, capture its addr/wdata/wstrb/we into the s_* registers, set s_valid=1 and move to BUSY on the same edge.
REQ-019 When both masters request in the same IDLE cycle, the block SHALL grant the master not granted last (round-robin); a lone requester SHALL always win.
REQ-020 In BUSY, s_* outputs SHALL stay stable; master input changes SHALL be ignored.
REQ-021 In BUSY, the first s_ready=1 SHALL latch s_rdata, clear s_valid and move to RESP on that edge.
REQ-022 In RESP, the block SHALL assert the granted master's ready for exactly one cycle, with its rdata = latched data and err=0, then return to IDLE.
REQ-023 A 16-bit wait counter SHALL clear on entry to BUSY and increment on each BUSY cycle without s_ready.
REQ-024 When the counter equals TIMEOUT_CYCLES, the block SHALL clear s_valid and enter RESP with rdata=ERR_RDATA and err=1.
REQ-025 If s_ready and timeout occur in the same cycle, s_ready SHALL win (err=0).
REQ-026 The non-granted master's ready, err and rdata SHALL be 0 at all times.
REQ-027 Each transaction SHALL take at least 3 cycles from IDLE grant to master ready (grant, one or more BUSY cycles, RESP); no arbitration SHALL occur in BUSY or RESP.
REQ-028 Masters SHALL drop valid in the cycle after ready; a valid still high in IDLE SHALL be treated as a new request.
REQ-029 A master dropping valid during BUSY SHALL NOT abort the transaction; the ready pulse is still issued.

Reset
REQ-030 On rst=0, asynchronously: state=IDLE, all outputs 0, counter=0, last-grant=m1 (so m0 wins the first contention).
REQ-031 Reset during BUSY or RESP SHALL abandon the transaction with no ready pulse.

Structure
REQ-032 Package mmio_pkg SHALL hold the state enum, default TIMEOUT_CYCLES and ERR_RDATA.
REQ-033 Round-robin selection SHALL be a sub-module, rr_arb2 (req[1:0], last-grant in; one-hot grant out; combinational).

Verification
REQ-034 m0 read of 0x4000_4010, slave ready 2 cycles after s_valid with 0x1234_5678 -> m0_ready pulse, m0_rdata=0x1234_5678, m0_err=0, m1 outputs 0.
REQ-035 m0 and m1 requesting together out of reset -> m0 served first, then m1; repeated contention alternates grants.
REQ-036 Slave never ready, TIMEOUT_CYCLES=4 -> s_valid drops after 4 wait cycles; m0_ready with rdata=0xDEAD_BEEF, err=1.
REQ-037 s_ready arriving in the timeout cycle -> err=0, slave data returned.
REQ-038 m1 write, wstrb=4'b0011 -> s_wstrb=4'b0011 and s_wdata stable throughout BUSY while m1 inputs toggle.
REQ-039 rst asserted mid-BUSY -> all outputs 0 immediately, no ready pulse, next request served normally.
